// File: rtl/serial_out_pkg.sv
// Shared constants for the serial_out command path: command codes, frame
// header default, loader FSM states and the mode levels understood by serial_out.
package serial_out_pkg;

   localparam logic [7:0] CMD_LOAD_ONESHOT  = 8'h01;
   localparam logic [7:0] CMD_LOAD_REPEAT   = 8'h02;
   localparam logic [7:0] CMD_STOP          = 8'h03;
   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   localparam logic MODE_ONE_SHOT = 1'b0;
   localparam logic MODE_REPEAT   = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CMD  = 3'd1,
      S_OUT  = 3'd2,
      S_FREQ = 3'd3,
      S_CHK  = 3'd4,
      S_EXEC = 3'd5
   } loader_state_t;

   function automatic logic is_load_cmd(input logic [7:0] b);
      return (b == CMD_LOAD_ONESHOT) || (b == CMD_LOAD_REPEAT);
   endfunction

endpackage

// File: rtl/pattern_loader_gap_timer.sv
// gap_timer: counts idle cycles between received bytes and flags expiry
// when the count reaches TIMEOUT_CYCLES-1. Clear has priority over enable.
module gap_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CW-1:0] count;

   assign o_expire = (count == CW'(TIMEOUT_CYCLES - 1));

   // Gap counter: cleared by a byte or idle state, holds once expired
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (i_clear) begin
         count <= '0;
      end else if (i_enable && !o_expire) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pattern_loader.sv
// pattern_loader: assembles framed UART command bytes into output/frequency
// patterns and drives serial_out start/stop/mode.
// Optional feature macro: PATTERN_LOADER_CHKSUM_EN (adds the trailing XOR check byte).
module pattern_loader
   import serial_out_pkg::*;
#(
   parameter int unsigned DATA_BIT       = 32,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [7:0]          i_rx_data,
   input  logic                i_rx_done_tick,
   output logic                o_start,
   output logic                o_stop,
   output logic                o_mode,
   output logic [DATA_BIT-1:0] o_output_pattern,
   output logic [DATA_BIT-1:0] o_freq_pattern,
   output logic                o_frame_err
);

   localparam int unsigned NBYTES = DATA_BIT / 8;
   localparam int unsigned CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

`ifdef PATTERN_LOADER_CHKSUM_EN
   localparam loader_state_t S_AFTER_PAYLOAD = S_CHK;
`else
   localparam loader_state_t S_AFTER_PAYLOAD = S_EXEC;
`endif

   loader_state_t       state, state_next;
   logic [CW-1:0]       cnt;
   logic [DATA_BIT-1:0] out_shadow;
   logic [DATA_BIT-1:0] freq_shadow;
   logic                cmd_repeat;
   logic                cmd_stop;
   logic                expire;
   logic                start_next;
   logic                stop_next;
   logic                err_next;

`ifdef PATTERN_LOADER_CHKSUM_EN
   logic [7:0]          chk;
`endif

   gap_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_gap_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clear  (i_rx_done_tick || (state == S_IDLE)),
      .i_enable (state != S_IDLE),
      .o_expire (expire)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and pulse decode; a byte in the expiry cycle takes priority over the timeout
   always_comb begin
      state_next = state;
      start_next = 1'b0;
      stop_next  = 1'b0;
      err_next   = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_rx_done_tick && (i_rx_data == SYNC_BYTE)) begin
               state_next = S_CMD;
            end
         end
         S_CMD: begin
            if (i_rx_done_tick) begin
               if (is_load_cmd(i_rx_data)) begin
                  state_next = S_OUT;
               end else if (i_rx_data == CMD_STOP) begin
                  state_next = S_AFTER_PAYLOAD;
               end else begin
                  err_next   = 1'b1;
                  state_next = S_IDLE;
               end
            end
         end
         S_OUT: begin
            if (i_rx_done_tick && (cnt == LAST)) begin
               state_next = S_FREQ;
            end
         end
         S_FREQ: begin
            if (i_rx_done_tick && (cnt == LAST)) begin
               state_next = S_AFTER_PAYLOAD;
            end
         end
`ifdef PATTERN_LOADER_CHKSUM_EN
         S_CHK: begin
            if (i_rx_done_tick) begin
               if (i_rx_data == chk) begin
                  state_next = S_EXEC;
               end else begin
                  err_next   = 1'b1;
                  state_next = S_IDLE;
               end
            end
         end
`endif
         S_EXEC: begin
            start_next = !cmd_stop;
            stop_next  = cmd_stop;
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
      if (!i_rx_done_tick && expire && (state != S_IDLE) && (state != S_EXEC)) begin
         err_next   = 1'b1;
         state_next = S_IDLE;
      end
   end

   // Byte capture: command flags, byte index and shadow pattern buffers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         out_shadow  <= '0;
         freq_shadow <= '0;
         cmd_repeat  <= 1'b0;
         cmd_stop    <= 1'b0;
      end else if (i_rx_done_tick) begin
         case (state)
            S_CMD: begin
               cnt        <= '0;
               cmd_repeat <= (i_rx_data == CMD_LOAD_REPEAT);
               cmd_stop   <= (i_rx_data == CMD_STOP);
            end
            S_OUT: begin
               out_shadow[{cnt, 3'b000} +: 8] <= i_rx_data;
               cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
            S_FREQ: begin
               freq_shadow[{cnt, 3'b000} +: 8] <= i_rx_data;
               cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef PATTERN_LOADER_CHKSUM_EN
   // Running XOR of the command byte and every payload byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk <= '0;
      end else if (i_rx_done_tick) begin
         if (state == S_CMD) begin
            chk <= i_rx_data;
         end else if ((state == S_OUT) || (state == S_FREQ)) begin
            chk <= chk ^ i_rx_data;
         end
      end
   end
`endif

   // Registered outputs: pulses, and pattern/mode update only on an executed load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_start          <= 1'b0;
         o_stop           <= 1'b0;
         o_frame_err      <= 1'b0;
         o_mode           <= MODE_ONE_SHOT;
         o_output_pattern <= '0;
         o_freq_pattern   <= '0;
      end else begin
         o_start     <= start_next;
         o_stop      <= stop_next;
         o_frame_err <= err_next;
         if (start_next) begin
            o_output_pattern <= out_shadow;
            o_freq_pattern   <= freq_shadow;
            o_mode           <= cmd_repeat ? MODE_REPEAT : MODE_ONE_SHOT;
         end
      end
   end

endmodule

// File: tb/tb_pattern_loader.sv
// Self-checking bench for pattern_loader: table of directed frames, timeout
// boundary and mid-frame reset sequences, then random frames against a
// frame-level reference model. Honours PATTERN_LOADER_CHKSUM_EN.
`timescale 1ns/1ps
module tb_pattern_loader;

   localparam int TMO = 40;
`ifdef PATTERN_LOADER_CHKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_tick = 1'b0;
   logic        start, stop, mode, frame_err;
   logic [31:0] out_pat, freq_pat;

   pattern_loader #(
      .DATA_BIT       (32),
      .TIMEOUT_CYCLES (TMO),
      .SYNC_BYTE      (8'hA5)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_rx_data        (rx_data),
      .i_rx_done_tick   (rx_tick),
      .o_start          (start),
      .o_stop           (stop),
      .o_mode           (mode),
      .o_output_pattern (out_pat),
      .o_freq_pattern   (freq_pat),
      .o_frame_err      (frame_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_start = 0, n_stop = 0, n_err = 0;
   int last_tick = 0, last_lat = 0;
   always @(negedge clk) begin
      if (start) n_start++;
      if (stop) n_stop++;
      if (frame_err) n_err++;
      if (start || stop) last_lat = cyc - last_tick;
   end

   int errors = 0, checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   logic [7:0] fq[$];

   // Frame from the protocol rules: SYNC, CMD, payload LSB first, optional XOR check byte
   task automatic build(input logic [7:0] cmd, input logic [31:0] op, input logic [31:0] fp,
                        input logic [7:0] cx, input int trunc, input bit lead_en, input logic [7:0] lead);
      logic [7:0] x;
      fq.delete();
      fq.push_back(8'hA5);
      fq.push_back(cmd);
      x = cmd;
      if (cmd == 8'h01 || cmd == 8'h02) begin
         for (int i = 0; i < 4; i++) begin fq.push_back(op[8*i +: 8]); x ^= op[8*i +: 8]; end
         for (int i = 0; i < 4; i++) begin fq.push_back(fp[8*i +: 8]); x ^= fp[8*i +: 8]; end
      end
      if (CK && cmd >= 8'h01 && cmd <= 8'h03) fq.push_back(x ^ cx);
      if (trunc != 0) while (fq.size() > trunc) void'(fq.pop_back());
      if (lead_en) fq.push_front(lead);
   endtask

   task automatic send_byte(input logic [7:0] b, input int idle);
      repeat (idle) @(negedge clk);
      rx_data   = b;
      rx_tick   = 1'b1;
      last_tick = cyc;
      @(negedge clk);
      rx_tick = 1'b0;
   endtask

   task automatic run(input string name, input logic [7:0] cmd, input logic [31:0] op, input logic [31:0] fp,
                      input logic [7:0] cx, input int trunc, input bit lead_en, input logic [7:0] lead,
                      input int gap, input int slow_idx, input int slow_gap,
                      input int e_start, input int e_stop, input int e_err,
                      input logic [31:0] e_out, input logic [31:0] e_freq, input logic e_mode);
      int s0, p0, r0;
      build(cmd, op, fp, cx, trunc, lead_en, lead);
      s0 = n_start; p0 = n_stop; r0 = n_err;
      last_lat = 0;
      for (int i = 0; i < fq.size(); i++) send_byte(fq[i], (i == slow_idx) ? slow_gap : gap);
      repeat (TMO + 6) @(negedge clk);
      check({name, ":start_pulses"}, n_start - s0, e_start);
      check({name, ":stop_pulses"}, n_stop - p0, e_stop);
      check({name, ":err_pulses"}, n_err - r0, e_err);
      check({name, ":output_pattern"}, out_pat, e_out);
      check({name, ":freq_pattern"}, freq_pat, e_freq);
      check({name, ":mode"}, mode, e_mode);
      if (e_start + e_stop > 0) check({name, ":latency"}, last_lat, 2);
   endtask

   typedef struct {
      string       name;
      logic [7:0]  cmd;
      logic [31:0] op, fp;
      logic [7:0]  cx;
      int          trunc;
      bit          lead_en;
      int          e_start, e_stop, e_err;
      logic [31:0] e_out, e_freq;
      logic        e_mode;
   } vec_t;

   vec_t tbl[8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog time_limit actual=expired required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] m_out, m_freq, op, fp;
      logic        m_mode;
      logic [7:0]  cmd, cx, lead;
      bit          lead_en;
      int          trunc, len, es, ep, ee, s0, p0, r0;

      tbl[0] = '{"s1_load", 8'h01, 32'h12345678, 32'h0000FFFF, 8'h00, 0, 0, 1, 0, 0, 32'h12345678, 32'h0000FFFF, 1'b0};
      tbl[1] = '{"s2_stop", 8'h03, 32'h0, 32'h0, 8'h00, 0, 0, 0, 1, 0, 32'h12345678, 32'h0000FFFF, 1'b0};
      tbl[2] = '{"s3_badchk", 8'h01, 32'h12345678, 32'h0000FFFF, 8'h03, 0, 0,
                 CK ? 0 : 1, 0, CK ? 1 : 0, 32'h12345678, 32'h0000FFFF, 1'b0};
      tbl[3] = '{"s3_badchk_new", 8'h02, 32'hDEADBEEF, 32'hCAFEF00D, 8'h5A, 0, 0,
                 CK ? 0 : 1, 0, CK ? 1 : 0, CK ? 32'h12345678 : 32'hDEADBEEF,
                 CK ? 32'h0000FFFF : 32'hCAFEF00D, CK ? 1'b0 : 1'b1};
      tbl[4] = '{"s4_timeout", 8'h01, 32'h12345678, 32'h0000FFFF, 8'h00, 4, 0, 0, 0, 1,
                 CK ? 32'h12345678 : 32'hDEADBEEF, CK ? 32'h0000FFFF : 32'hCAFEF00D, CK ? 1'b0 : 1'b1};
      tbl[5] = '{"s4_repeat", 8'h02, 32'h12345678, 32'h0000FFFF, 8'h00, 0, 0, 1, 0, 0, 32'h12345678, 32'h0000FFFF, 1'b1};
      tbl[6] = '{"s5_badcmd", 8'h07, 32'h0, 32'h0, 8'h00, 0, 1, 0, 0, 1, 32'h12345678, 32'h0000FFFF, 1'b1};
      tbl[7] = '{"stop_keeps_repeat", 8'h03, 32'h0, 32'h0, 8'h00, 0, 0, 0, 1, 0, 32'h12345678, 32'h0000FFFF, 1'b1};

      // Reset state
      repeat (3) @(negedge clk);
      check("reset:start", start, 0);
      check("reset:stop", stop, 0);
      check("reset:err", frame_err, 0);
      check("reset:mode", mode, 0);
      check("reset:output_pattern", out_pat, 0);
      check("reset:freq_pattern", freq_pat, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int k = 0; k < 8; k++) begin
         run(tbl[k].name, tbl[k].cmd, tbl[k].op, tbl[k].fp, tbl[k].cx, tbl[k].trunc, tbl[k].lead_en, 8'h00,
             1, -1, 0, tbl[k].e_start, tbl[k].e_stop, tbl[k].e_err, tbl[k].e_out, tbl[k].e_freq, tbl[k].e_mode);
      end

      // Byte landing in the expiry cycle is accepted; one cycle later the frame is dropped
      run("gap_at_expiry", 8'h01, 32'h01020304, 32'h11121314, 8'h00, 0, 0, 8'h00, 1, 4, TMO - 1,
          1, 0, 0, 32'h01020304, 32'h11121314, 1'b0);
      run("gap_past_expiry", 8'h02, 32'h05060708, 32'h15161718, 8'h00, 0, 0, 8'h00, 1, 4, TMO,
          0, 0, 1, 32'h01020304, 32'h11121314, 1'b0);

      // Reset mid-payload: nothing emitted, outputs cleared, next frame executes alone
      build(8'h02, 32'h99887766, 32'h55443322, 8'h00, 4, 0, 8'h00);
      s0 = n_start; p0 = n_stop; r0 = n_err;
      for (int i = 0; i < fq.size(); i++) send_byte(fq[i], 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (TMO + 6) @(negedge clk);
      check("midreset:pulses", (n_start - s0) + (n_stop - p0) + (n_err - r0), 0);
      check("midreset:output_pattern", out_pat, 0);
      check("midreset:freq_pattern", freq_pat, 0);
      check("midreset:mode", mode, 0);
      run("after_reset", 8'h01, 32'hA1B2C3D4, 32'h0F1E2D3C, 8'h00, 0, 0, 8'h00, 1, -1, 0,
          1, 0, 0, 32'hA1B2C3D4, 32'h0F1E2D3C, 1'b0);
      m_out = 32'hA1B2C3D4; m_freq = 32'h0F1E2D3C; m_mode = 1'b0;

      // Random frames against the frame-level model
      for (int k = 0; k < 24; k++) begin
         case ($urandom_range(0, 3))
            0: cmd = 8'h01;
            1: cmd = 8'h02;
            2: cmd = 8'h03;
            default: begin
               cmd = 8'($urandom_range(0, 255));
               while (cmd >= 8'h01 && cmd <= 8'h03) cmd = 8'($urandom_range(0, 255));
            end
         endcase
         op = $urandom;
         fp = $urandom;
         cx = (CK && $urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         lead_en = ($urandom_range(0, 3) == 0);
         lead = 8'($urandom_range(0, 255));
         while (lead == 8'hA5) lead = 8'($urandom_range(0, 255));
         build(cmd, op, fp, cx, 0, 0, 8'h00);
         len = fq.size();
         trunc = ($urandom_range(0, 5) == 0) ? $urandom_range(1, len - 1) : 0;
         es = 0; ep = 0; ee = 0;
         if (trunc != 0 || cmd < 8'h01 || cmd > 8'h03 || cx != 8'h00) ee = 1;
         else if (cmd == 8'h03) ep = 1;
         else begin
            es = 1; m_out = op; m_freq = fp; m_mode = (cmd == 8'h02);
         end
         run($sformatf("rand%0d", k), cmd, op, fp, cx, trunc, lead_en, lead,
             $urandom_range(1, 3), -1, 0, es, ep, ee, m_out, m_freq, m_mode);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
